// File: rtl/mips_mem_responder_if.sv
// Instruction and data bus between the multicycle MIPS core (master)
// and its memory responder (slave).
interface mips_mem_responder_if;
  logic [31:0] instr_addr;
  logic [31:0] instr_in;
  logic [31:0] data_addr;
  logic [31:0] data_out;
  logic        data_rd_wr;
  logic [31:0] data_in;

  modport master (
    output instr_addr, data_addr, data_out, data_rd_wr,
    input  instr_in, data_in
  );

  modport slave (
    input  instr_addr, data_addr, data_out, data_rd_wr,
    output instr_in, data_in
  );
endinterface

// File: rtl/mips_mem_responder.sv
// Memory responder for the multicycle MIPS core: one word-addressed array
// serving fetches and data reads, with a 2-entry posted write buffer that
// forwards to both read ports, plus a preload port for program images.
module mips_mem_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned ADDR_W     = 19,
  parameter logic [31:0] INSTR_FILL = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  mips_mem_responder_if.slave bus,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic [1:0]        wbuf_count,
  output logic              instr_err,
  output logic              data_err,
  output logic              wr_overflow
);

  logic [31:0]       mem [2**ADDR_W];

  logic [ADDR_W-1:0] ent_idx  [2];
  logic [31:0]       ent_data [2];
  logic [ADDR_W-1:0] n_idx    [2];
  logic [31:0]       n_data   [2];
  logic [1:0]        n_count;

  logic [31:0]       instr_q;
  logic [31:0]       data_q;

  logic              wr_seen;
  logic [31:0]       last_addr;
  logic [31:0]       last_data;

  logic              i_ok, d_ok;
  logic [ADDR_W-1:0] i_idx, d_idx;
  logic [31:0]       i_word, d_word;
  logic              drain, wr_accept, enq_try, enq_ok;

  assign bus.instr_in = instr_q;
  assign bus.data_in  = data_q;

  function automatic logic addr_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a[1:0] == 2'b00) && ((off >> (ADDR_W + 2)) == 32'd0);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_idx(input logic [31:0] a);
    return ADDR_W'((a - BASE_ADDR) >> 2);
  endfunction

  // Address decode and forwarding lookup; the tail entry is newest, so it wins.
  always_comb begin
    i_ok   = addr_ok(bus.instr_addr);
    d_ok   = addr_ok(bus.data_addr);
    i_idx  = addr_idx(bus.instr_addr);
    d_idx  = addr_idx(bus.data_addr);
    i_word = mem[i_idx];
    d_word = mem[d_idx];
    if (wbuf_count != 2'd0 && ent_idx[0] == i_idx) i_word = ent_data[0];
    if (wbuf_count == 2'd2 && ent_idx[1] == i_idx) i_word = ent_data[1];
    if (wbuf_count != 2'd0 && ent_idx[0] == d_idx) d_word = ent_data[0];
    if (wbuf_count == 2'd2 && ent_idx[1] == d_idx) d_word = ent_data[1];
  end

  // Write acceptance (edge-based on the held bus level) and buffer next state.
  always_comb begin
    drain     = !ld_en && (wbuf_count != 2'd0);
    wr_accept = !bus.data_rd_wr &&
                (!wr_seen || bus.data_addr != last_addr || bus.data_out != last_data);
    enq_try   = wr_accept && d_ok;
    enq_ok    = enq_try && (wbuf_count != 2'd2 || drain);
    n_idx     = ent_idx;
    n_data    = ent_data;
    n_count   = wbuf_count;
    // Pop shifts the second entry to the head first, so the append slot is
    // simply the post-pop occupancy (never 2 when enq_ok holds).
    if (drain) begin
      n_idx[0]  = ent_idx[1];
      n_data[0] = ent_data[1];
      n_count   = wbuf_count - 2'd1;
    end
    if (enq_ok) begin
      n_idx[n_count[0]]  = d_idx;
      n_data[n_count[0]] = bus.data_out;
      n_count            = n_count + 2'd1;
    end
  end

  // Single array write port: preload has priority over buffer drain.
  always_ff @(posedge clk) begin
    if (ld_en)      mem[ld_addr]    <= ld_data;
    else if (drain) mem[ent_idx[0]] <= ent_data[0];
  end

  // Registered read data, error pulses, write tracker and buffer state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q     <= '0;
      data_q      <= '0;
      instr_err   <= 1'b0;
      data_err    <= 1'b0;
      wr_overflow <= 1'b0;
      wbuf_count  <= '0;
      ent_idx     <= '{default: '0};
      ent_data    <= '{default: '0};
      wr_seen     <= 1'b0;
      last_addr   <= '0;
      last_data   <= '0;
    end else begin
      instr_q   <= i_ok ? i_word : INSTR_FILL;
      instr_err <= !i_ok;
      data_err  <= 1'b0;
      if (bus.data_rd_wr) begin
        data_q   <= d_ok ? d_word : '0;
        data_err <= !d_ok;
        wr_seen  <= 1'b0;
      end else if (wr_accept) begin
        wr_seen   <= 1'b1;
        last_addr <= bus.data_addr;
        last_data <= bus.data_out;
        data_err  <= !d_ok;
      end
      if (enq_try && !enq_ok) wr_overflow <= 1'b1;
      ent_idx    <= n_idx;
      ent_data   <= n_data;
      wbuf_count <= n_count;
    end
  end

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
Memory-side responder for the multicycle MIPS core's instruction and data buses. Serves instruction fetches and data reads and writes from one word-addressed array. Writes pass through a 2-entry posted write buffer, with read-after-write forwarding. A testbench load port preloads program and data images.

Parameters:
BASE_ADDR, 32'h80000000, byte address of array word 0
ADDR_W, 19, array depth is 2**ADDR_W words (default window 0x80000000-0x801FFFFF)
INSTR_FILL, 32'h00000000, word returned on a faulting instruction fetch (NOP)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
instr_addr  in  32  instruction byte address from core
instr_in  out  32  fetched instruction word to core
data_addr  in  32  data byte address from core
data_out  in  32  store data from core
data_rd_wr  in  1  1=read, 0=write
data_in  out  32  load data to core
ld_en  in  1  testbench preload strobe
ld_addr  in  ADDR_W  preload word index
ld_data  in  32  preload word
wbuf_count  out  2  write-buffer occupancy, 0..2
instr_err  out  1  one-cycle pulse: fetch was misaligned or out of window
data_err  out  1  one-cycle pulse: data access was misaligned or out of window
wr_overflow  out  1  sticky: a write was dropped because the buffer was full

Behaviour:
- Reset (reset=0, async): instr_in=0, data_in=0, wbuf_count=0, buffer emptied, instr_err=0, data_err=0, wr_overflow=0, prev-write tracker cleared to "no write". Array contents are not reset.
- Address decode: idx = (addr - BASE_ADDR) >> 2. An address is valid iff addr[1:0]==0 and BASE_ADDR <= addr < BASE_ADDR + 4*2**ADDR_W.
- Fetch: every posedge, instr_in <= word(instr_addr). Latency is 1 cycle.
  - Invalid fetch: instr_in <= INSTR_FILL and instr_err pulses for 1 cycle.
- Data read (data_rd_wr=1): every posedge, data_in <= word(data_addr). Latency is 1 cycle.
  - Invalid read: data_in <= 0 and data_err pulses.
  - The prev-write tracker resets to "no write".
- word(a): if a buffer entry matches idx, return the data of the newest matching entry; otherwise return array[idx]. Both ports forward.
- Data write (data_rd_wr=0): the core holds the bus level for several cycles, so acceptance is edge-based.
  - A write is accepted on a cycle where data_rd_wr=0 and either (a) the previous cycle had data_rd_wr=1 or came from reset, or (b) {data_addr, data_out} differs from the last accepted write.
  - A repeated identical {addr, data} while data_rd_wr stays 0 is ignored.
  - data_in holds its value during write cycles.
- Invalid write: dropped, data_err pulses, buffer unchanged.
- Accepted valid write: enqueue {idx, data_out} at the tail of the FIFO, in order.
  - If the buffer is full (2 entries) and no drain happens this cycle, the write is dropped and wr_overflow is set (cleared only by reset).
  - If the buffer is full and a drain happens the same cycle, the enqueue succeeds.
- Drain: one array write port. Each cycle with ld_en=0 and buffer non-empty, the head is written to the array and popped.
  - ld_en=1 takes the port: array[ld_addr] <= ld_data and no drain that cycle.
  - ld_en does not flush the buffer. A buffered entry to the same idx later overwrites the preload.
- Same-cycle enqueue and drain: occupancy unchanged. A read that cycle still forwards from the entry being drained, so no stale data is returned.
- wbuf_count is registered and reflects occupancy after the current edge.
- Reset mid-drain: pending writes are lost. This is intentional; the bench must not rely on them.

Test Plan:
- Preload via ld_en: array[0x8000]=32'h24020005. Set instr_addr=32'h80020000 -> next cycle instr_in=32'h24020005, instr_err=0.
- Hold data_rd_wr=0, data_addr=32'h8011FFFC, data_out=32'hDEADBEEF for 5 cycles -> exactly one write accepted; wbuf_count peaks at 1 then returns to 0. Then read the same address -> data_in=32'hDEADBEEF.
- With ld_en=1 held, perform two distinct writes then a third -> wbuf_count=2, the third is dropped, wr_overflow=1. Release ld_en -> count drains 2,1,0.
- Hold ld_en=1. Write 32'h11111111 then 32'h22222222 to 32'h80100000, then read it -> data_in=32'h22222222 (newest entry forwarded).
- Fetch 32'h80020002 -> instr_in=32'h0, instr_err pulses. Read 32'h7FFFFFFC -> data_in=0, data_err pulses.
- Assert reset=0 asynchronously with 2 entries buffered -> wbuf_count=0 and all outputs 0 immediately, with no wait for a clock edge.
